timer_ctrl: RTL and testbench

//  Control sequencer for the hr/min/sec/ms countdown datapath. Conditions raw

---
 rtl/timer_ctrl_if.sv | 15 +
 rtl/timer_ctrl.sv | 111 +++++++++++
 tb/tb_timer_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: board buttons, datapath status and control outputs around timer_ctrl.
// The slave modport is the sequencer; the master side is the board/datapath.
interface timer_ctrl_if;
    logic       start_btn, hr_btn, min_btn, sec_btn, zero_flag;
    logic       hr_inc, min_inc, sec_inc, run_en, clr, led;
    logic [1:0] state;
    modport master (
        output start_btn, hr_btn, min_btn, sec_btn, zero_flag,
        input  hr_inc, min_inc, sec_inc, run_en, clr, led, state
    );
    modport slave (
        input  start_btn, hr_btn, min_btn, sec_btn, zero_flag,
        output hr_inc, min_inc, sec_inc, run_en, clr, led, state
    );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: button conditioning plus IDLE/RUN/PAUSE/DONE sequencer for the countdown datapath.
// Define TIMER_AUTOREPEAT_EN to auto-repeat held hr/min/sec buttons while in IDLE/PAUSE.
module timer_ctrl #(
    parameter int DEBOUNCE_MS      = 20,
    parameter int ALARM_MS         = 5000,
    parameter int REPEAT_DELAY_MS  = 500,
    parameter int REPEAT_PERIOD_MS = 100
) (
    input logic         clk_1khz,
    input logic         reset_in,
    timer_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11;
    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int AW = $clog2(ALARM_MS + 1);

    logic [3:0]    raw, s1, s2, deb, deb_q, evt;
    logic [DW-1:0] db_cnt [4];
    logic [AW-1:0] alarm_cnt;
    logic [1:0]    state, state_nx;
    logic [2:0]    inc, rep;
    logic          clr, inc_ok, done_exit;

    if (DEBOUNCE_MS < 1 || REPEAT_PERIOD_MS < 1 || REPEAT_PERIOD_MS > REPEAT_DELAY_MS) begin : g_param_check
        $error("timer_ctrl: DEBOUNCE_MS must be >=1 and REPEAT_PERIOD_MS within 1..REPEAT_DELAY_MS");
    end

    // bit order everywhere: 0 start, 1 hr, 2 min, 3 sec
    assign raw       = {bus.sec_btn, bus.min_btn, bus.hr_btn, bus.start_btn};
    assign evt       = deb & ~deb_q;
    assign inc_ok    = (state == IDLE) || (state == PAUSE);
    assign done_exit = (|evt) || (alarm_cnt == AW'(ALARM_MS - 1));

    always_ff @(posedge clk_1khz or negedge reset_in) begin
        if (!reset_in) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_q <= deb;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == deb[i]) db_cnt[i] <= '0;
                else if (db_cnt[i] == DW'(DEBOUNCE_MS - 1)) begin
                    deb[i]    <= s2[i];
                    db_cnt[i] <= '0;
                end else db_cnt[i] <= db_cnt[i] + 1'b1;
            end
        end
    end

`ifdef TIMER_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY_MS + 1);
    logic [RW-1:0] rpt_cnt [3];

    always_comb begin
        rep = '0;
        for (int i = 0; i < 3; i++) rep[i] = deb[i+1] && (rpt_cnt[i] == RW'(REPEAT_DELAY_MS));
    end

    // after the first repeat the counter reloads so it hits the delay value once per period
    always_ff @(posedge clk_1khz or negedge reset_in) begin
        if (!reset_in) for (int i = 0; i < 3; i++) rpt_cnt[i] <= '0;
        else for (int i = 0; i < 3; i++)
            rpt_cnt[i] <= !(deb[i+1] && inc_ok) ? '0 :
                          rep[i] ? RW'(REPEAT_DELAY_MS - REPEAT_PERIOD_MS) : rpt_cnt[i] + 1'b1;
    end
`else
    assign rep = '0;
`endif

    always_ff @(posedge clk_1khz or negedge reset_in) begin
        if (!reset_in) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (evt[0] && !bus.zero_flag) state_nx = RUN;
            RUN:     state_nx = bus.zero_flag ? DONE : evt[0] ? PAUSE : RUN;
            PAUSE:   if (evt[0]) state_nx = RUN;
            default: if (done_exit) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_1khz or negedge reset_in) begin
        if (!reset_in) begin
            clr       <= 1'b0;
            inc       <= '0;
            alarm_cnt <= '0;
        end else begin
            clr       <= (state == DONE) && done_exit;
            inc       <= inc_ok ? (evt[3:1] | rep) : 3'b000;
            alarm_cnt <= (state == DONE) ? alarm_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        bus.state   = state;
        bus.led     = (state == DONE);
        bus.run_en  = (state == RUN) && !bus.zero_flag;
        bus.clr     = clr;
        bus.hr_inc  = inc[0];
        bus.min_inc = inc[1];
        bus.sec_inc = inc[2];
    end
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: randomized self-checking bench for timer_ctrl with small timing parameters.
// Expected timing comes from the press-to-event latency and repeat schedule arithmetic.
module tb_timer_ctrl;
    localparam int DB = 4, AL = 10, RD = 8, RP = 3;
    localparam int LAT = DB + 3;
`ifdef TIMER_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk_1khz = 1'b0;
    logic       reset_in = 1'b0;
    logic [3:0] btn = '0;
    logic       zero = 1'b0;
    logic [7:0] outs;
    int         checks = 0;
    int         fails = 0;

    timer_ctrl_if bus();
    assign bus.start_btn = btn[0];
    assign bus.hr_btn    = btn[1];
    assign bus.min_btn   = btn[2];
    assign bus.sec_btn   = btn[3];
    assign bus.zero_flag = zero;
    // {state[1:0], run_en, led, clr, hr_inc, min_inc, sec_inc}
    assign outs = {bus.state, bus.run_en, bus.led, bus.clr, bus.hr_inc, bus.min_inc, bus.sec_inc};

    timer_ctrl #(.DEBOUNCE_MS(DB), .ALARM_MS(AL), .REPEAT_DELAY_MS(RD), .REPEAT_PERIOD_MS(RP))
        dut (.clk_1khz(clk_1khz), .reset_in(reset_in), .bus(bus));

    always #5 clk_1khz = ~clk_1khz;

    task automatic step(input int n);
        repeat (n) @(negedge clk_1khz);
    endtask

    task automatic do_reset;
        reset_in = 1'b0;
        btn = '0;
        zero = 1'b0;
        step(2);
        reset_in = 1'b1;
        step(1);
    endtask

    task automatic press(input logic [3:0] m);
        btn = btn | m;
        step(LAT - 1);
    endtask

    task automatic release_all;
        btn = '0;
        step(DB + 5);
    endtask

    function automatic bit rep_due(input int o, input int held);
        if (o < 0 || o >= held) return 1'b0;
        if (o == 0) return 1'b1;
        return AR && o >= RD && ((o - RD) % RP) == 0;
    endfunction

    task automatic test_reset;
        reset_in = 1'b0;
        step(2);
        checks++;
        if (outs !== 8'h00) begin
            fails++;
            $display("FAIL reset_state outs=%b expected=%b", outs, 8'h00);
        end
        reset_in = 1'b1;
        step(1);
    endtask

    task automatic test_reset_mid_run;
        press(4'b0001);
        step(1);
        release_all();
        step(3);
        checks++;
        if (outs[7:5] !== 3'b011) begin
            fails++;
            $display("FAIL mid_run_setup state/run_en=%b expected=%b", outs[7:5], 3'b011);
        end
        #1 reset_in = 1'b0;
        #1;
        checks++;
        if (outs !== 8'h00) begin
            fails++;
            $display("FAIL async_reset outs=%b expected=%b", outs, 8'h00);
        end
        step(2);
        reset_in = 1'b1;
        step(1);
    endtask

    task automatic test_sec_press;
        int pulses;
        btn[3] = 1'b1;
        for (int k = 1; k <= LAT + 4; k++) begin
            step(1);
            checks++;
            if (bus.sec_inc !== (k == LAT)) begin
                fails++;
                $display("FAIL sec_clean cycle=%0d sec_inc=%b expected=%b", k, bus.sec_inc, k == LAT);
            end
        end
        release_all();
        for (int it = 0; it < 4; it++) begin
            int nb;
            nb = $urandom_range(1, 3);
            pulses = 0;
            for (int g = 0; g < nb; g++) begin
                int h, l;
                h = $urandom_range(1, DB - 1);
                l = $urandom_range(1, DB - 1);
                btn[3] = 1'b1;
                for (int c = 0; c < h; c++) begin step(1); pulses += bus.sec_inc; end
                btn[3] = 1'b0;
                for (int c = 0; c < l; c++) begin step(1); pulses += bus.sec_inc; end
            end
            btn[3] = 1'b1;
            for (int k = 1; k <= LAT + 4; k++) begin
                step(1);
                if (k == LAT) begin
                    checks++;
                    if (bus.sec_inc !== 1'b1) begin
                        fails++;
                        $display("FAIL sec_bounce_pulse iter=%0d sec_inc=%b expected=1", it, bus.sec_inc);
                    end
                end else pulses += bus.sec_inc;
            end
            checks++;
            if (pulses != 0) begin
                fails++;
                $display("FAIL sec_bounce_extra iter=%0d extra_pulses=%0d expected=0", it, pulses);
            end
            release_all();
        end
    endtask

    task automatic test_start_cycle;
        logic [2:0] exp_sr [3];
        exp_sr[0] = 3'b011;
        exp_sr[1] = 3'b100;
        exp_sr[2] = 3'b011;
        zero = 1'b0;
        for (int p = 0; p < 3; p++) begin
            press(4'b0001);
            checks++;
            if (outs[7:6] !== (p == 0 ? 2'b00 : p == 1 ? 2'b01 : 2'b10)) begin
                fails++;
                $display("FAIL start_early press=%0d state=%b changed before event", p, outs[7:6]);
            end
            step(1);
            checks++;
            if (outs[7:5] !== exp_sr[p]) begin
                fails++;
                $display("FAIL start_press press=%0d state/run_en=%b expected=%b", p, outs[7:5], exp_sr[p]);
            end
            release_all();
        end
    endtask

    task automatic test_done_alarm;
        zero = 1'b1;
        #1;
        checks++;
        if (bus.run_en !== 1'b0) begin
            fails++;
            $display("FAIL zero_run_en run_en=%b expected=0", bus.run_en);
        end
        step(1);
        checks++;
        if (outs[7:3] !== 5'b11010) begin
            fails++;
            $display("FAIL done_entry state/run/led/clr=%b expected=%b", outs[7:3], 5'b11010);
        end
        for (int k = 2; k <= AL; k++) begin
            step(1);
            checks++;
            if (outs[7:3] !== 5'b11010) begin
                fails++;
                $display("FAIL done_hold cycle=%0d state/run/led/clr=%b expected=%b", k, outs[7:3], 5'b11010);
            end
        end
        step(1);
        checks++;
        if (outs[7:3] !== 5'b00001) begin
            fails++;
            $display("FAIL alarm_exit state/run/led/clr=%b expected=%b", outs[7:3], 5'b00001);
        end
        step(1);
        checks++;
        if (outs[7:3] !== 5'b00000) begin
            fails++;
            $display("FAIL clr_one_cycle state/run/led/clr=%b expected=%b", outs[7:3], 5'b00000);
        end
        zero = 1'b0;
    endtask

    task automatic test_done_button;
        for (int it = 0; it < 3; it++) begin
            int j, b;
            do_reset();
            press(4'b0001);
            step(1);
            release_all();
            j = $urandom_range(0, 2);
            b = $urandom_range(1, 3);
            zero = 1'b1;
            step(j);
            btn[b] = 1'b1;
            step(LAT - 1);
            checks++;
            if (outs[7:3] !== 5'b11010) begin
                fails++;
                $display("FAIL done_btn_before iter=%0d outs=%b expected state 11 led 1", it, outs);
            end
            step(1);
            checks++;
            if (outs !== 8'b00001000) begin
                fails++;
                $display("FAIL done_btn_exit iter=%0d btn=%0d outs=%b expected=%b", it, b, outs, 8'b00001000);
            end
            release_all();
            zero = 1'b0;
        end
    endtask

    task automatic test_inc_gating;
        int pulses;
        do_reset();
        press(4'b0001);
        step(1);
        release_all();
        btn[1] = 1'b1;
        pulses = 0;
        for (int k = 0; k < LAT + 4; k++) begin step(1); pulses += bus.hr_inc; end
        checks++;
        if (pulses != 0 || outs[7:6] !== 2'b01) begin
            fails++;
            $display("FAIL run_suppress hr_pulses=%0d state=%b expected 0 pulses state 01", pulses, outs[7:6]);
        end
        release_all();
        press(4'b0001);
        step(1);
        release_all();
        press(4'b0110);
        step(1);
        checks++;
        if ({outs[7:6], outs[2:0]} !== 5'b10110) begin
            fails++;
            $display("FAIL pause_hr_min state/inc=%b expected=%b", {outs[7:6], outs[2:0]}, 5'b10110);
        end
        release_all();
        press(4'b0001);
        step(1);
        release_all();
        zero = 1'b1;
        step(AL + 2);
        press(4'b0001);
        step(1);
        checks++;
        if (outs[7:6] !== 2'b00) begin
            fails++;
            $display("FAIL idle_zero_start state=%b expected=00", outs[7:6]);
        end
        release_all();
        zero = 1'b0;
        press(4'b1001);
        step(1);
        checks++;
        if ({outs[7:5], outs[0]} !== 4'b0111) begin
            fails++;
            $display("FAIL start_with_sec state/run/sec=%b expected=%b", {outs[7:5], outs[0]}, 4'b0111);
        end
        release_all();
    endtask

    task automatic test_autorepeat;
        for (int it = 0; it < 2; it++) begin
            int held;
            do_reset();
            held = (it == 0) ? 20 : $urandom_range(9, 26);
            btn[2] = 1'b1;
            for (int k = 1; k <= held + LAT + 6; k++) begin
                step(1);
                checks++;
                if (bus.min_inc !== rep_due(k - LAT, held)) begin
                    fails++;
                    $display("FAIL autorepeat held=%0d offset=%0d min_inc=%b expected=%b",
                             held, k - LAT, bus.min_inc, rep_due(k - LAT, held));
                end
                if (k == held) btn[2] = 1'b0;
            end
            release_all();
        end
    endtask

    initial begin
        test_reset();
        test_sec_press();
        test_start_cycle();
        test_done_alarm();
        test_reset_mid_run();
        test_done_button();
        test_inc_gating();
        test_autorepeat();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
